fft_stage_scheduler: RTL and testbench
======================================

# fft_stage_scheduler

Frame-level sequencer for the in-place radix-2 pipeline FFT. It accepts a loaded frame and issues one start pulse per butterfly stage to the per-stage read/write address controller. Between stages it waits for that controller's done pulse and swaps the ping-pong RAM banks. When all log2(N) stages are complete, it presents the result bank through a valid/ready handshake.

## Interface
Parameters:
- N, 16: FFT points.
- SIZE, 4: log2(N); also the number of stages.
- TIMEOUT, 64: watchdog limit in cycles per stage. Used only when `FFT_STAGE_TIMEOUT_EN` is defined.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- frame_valid  in  1  input bank holds a complete frame.
- frame_ready  out  1  high only in IDLE. A frame is accepted on a clk edge where frame_valid & frame_ready.
- stage_start  out  1  one-cycle pulse that starts the stage controller.
- stage_idx  out  SIZE  current stage, 0..SIZE-1.
- tw_shift  out  SIZE  twiddle index shift, always SIZE-1-stage_idx.
- stage_done  in  1  done pulse from the stage controller.
- rd_bank  out  1  ping-pong bank being read.
- wr_bank  out  1  bank being written; always ~rd_bank.
- busy  out  1  high in every state except IDLE.
- result_valid  out  1  FFT result ready in result_bank.
- result_bank  out  1  bank holding the final result.
- result_ready  in  1  downstream consumer accepts the result.
- frame_cnt  out  8  completed-frame counter; wraps 255→0.
- timeout_err  out  1  sticky watchdog flag.

## Operation
- FSM states: IDLE, ISSUE, WAIT, ADVANCE, RESULT; one-hot, 5 bits.
- IDLE:
  - frame_ready=1.
  - On accept: stage_idx<=0, rd_bank<=0, timeout_err<=0, go to ISSUE.
- ISSUE (exactly one cycle):
  - stage_start=1, go to WAIT.
  - stage_done sampled in ISSUE is ignored.
- WAIT:
  - stage_start=0.
  - On stage_done=1, go to ADVANCE; otherwise stay.
- ADVANCE (one cycle):
  - rd_bank toggles.
  - If stage_idx==SIZE-1: go to RESULT and keep stage_idx.
  - Else: stage_idx increments and go to ISSUE.
- RESULT:
  - result_valid=1 and result_bank=rd_bank, which is SIZE mod 2.
  - Held until result_ready=1. Then frame_cnt increments and go to IDLE.
  - In RESULT, result_valid drops one cycle after the handshake edge.
- Ignored inputs:
  - stage_done in IDLE, ISSUE, ADVANCE or RESULT.
  - frame_valid outside IDLE.
- Reset values:
  - All outputs 0, except wr_bank=1 and tw_shift=SIZE-1.
  - FSM=IDLE, so frame_ready=1 on the cycle after reset.
- Reset mid-frame: on the next edge everything returns to reset values. No stage_start is issued, no result_valid is asserted, and frame_cnt is cleared.
- Combinational outputs: only frame_ready, wr_bank and tw_shift. All other outputs are registered.

## Timing
- Frame accepted at edge t0. stage_start is high in the cycle after t0.
- Per-stage spacing: stage_start in cycle c and stage_done in cycle c+d (d≥1) give ADVANCE in cycle c+d+1 and the next stage_start in cycle c+d+2.
- After the last stage's ADVANCE, result_valid is high in the following cycle.
- Minimum frame latency, from accept to result_valid, with d=1: 3·SIZE+1 cycles. That is 13 cycles for SIZE=4.
- stage_done coinciding with reset: reset wins.
- result_ready with frame_valid in the same cycle: RESULT goes to IDLE. The new frame is accepted no earlier than the next edge.

## Configuration
- `FFT_STAGE_TIMEOUT_EN` defined:
  - A cycle counter clears on entry to WAIT and counts while in WAIT.
  - If it reaches TIMEOUT without stage_done: timeout_err<=1 (sticky), FSM goes to IDLE, no result_valid is asserted, and frame_cnt is unchanged.
  - timeout_err clears on reset or on the next frame accept.
- `FFT_STAGE_TIMEOUT_EN` not defined:
  - No counter is synthesized and WAIT waits indefinitely.
  - The timeout_err port remains, tied to 0.

## Test plan
- Nominal frame, N=16/SIZE=4, stage_done 5 cycles after each stage_start:
  - 4 stage_start pulses with stage_idx 0,1,2,3 and tw_shift 3,2,1,0.
  - rd_bank 0,1,0,1 across the stages.
  - result_valid with result_bank=0; frame_cnt 0→1 after result_ready.
- Minimum latency, stage_done 1 cycle after each stage_start: result_valid asserted exactly 13 cycles after the accept edge.
- Backpressure:
  - result_ready held 0 for 10 cycles: result_valid stays high, frame_ready stays 0, and a frame_valid pulse is not accepted.
  - result_ready then goes 1: IDLE on the next cycle.
- Spurious inputs:
  - stage_done pulses in IDLE and in ISSUE cause no state change.
  - frame_valid during WAIT is ignored and stage_idx is unchanged.
- Reset mid-frame: rst_n=0 for 1 cycle during stage 2 WAIT. Next cycle busy=0, stage_idx=0, rd_bank=0, frame_cnt=0, and no stage_start appears.
- Timeout, with `FFT_STAGE_TIMEOUT_EN` defined and TIMEOUT=64:
  - Withhold stage_done in stage 1: timeout_err=1 after 64 WAIT cycles, FSM in IDLE, and no result_valid.
  - Next accept clears timeout_err.

Source files
------------

// File: rtl/fft_stage_scheduler_if.sv
// Handshake bundle between the FFT stage scheduler, the frame loader, the
// per-stage address controller and the result consumer.
interface fft_stage_scheduler_if #(
    parameter int SIZE = 4
);
    logic            frame_valid;
    logic            frame_ready;
    logic            stage_start;
    logic [SIZE-1:0] stage_idx;
    logic [SIZE-1:0] tw_shift;
    logic            stage_done;
    logic            result_valid;
    logic            result_bank;
    logic            result_ready;

    modport master (
        input  frame_valid, stage_done, result_ready,
        output frame_ready, stage_start, stage_idx, tw_shift,
               result_valid, result_bank
    );

    modport slave (
        output frame_valid, stage_done, result_ready,
        input  frame_ready, stage_start, stage_idx, tw_shift,
               result_valid, result_bank
    );
endinterface

// File: rtl/fft_stage_scheduler.sv
// Frame-level stage sequencer for the in-place radix-2 FFT with ping-pong banks.
// Optional per-stage watchdog enabled by defining FFT_STAGE_TIMEOUT_EN.
module fft_stage_scheduler #(
    parameter int N       = 16,
    parameter int SIZE    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fft_stage_scheduler_if.master bus,
    output logic                 rd_bank,
    output logic                 wr_bank,
    output logic                 busy,
    output logic [7:0]           frame_cnt,
    output logic                 timeout_err
);

    if (N != (1 << SIZE) || TIMEOUT < 1) begin : g_bad_cfg
        $error("fft_stage_scheduler: N must equal 2**SIZE and TIMEOUT must be positive");
    end

    localparam logic [SIZE-1:0] LAST_STAGE = SIZE'(SIZE - 1);

    typedef enum logic [4:0] {
        IDLE    = 5'b00001,
        ISSUE   = 5'b00010,
        WAIT    = 5'b00100,
        ADVANCE = 5'b01000,
        RESULT  = 5'b10000
    } state_e;

    state_e          state_q, state_d;
    logic [SIZE-1:0] stage_idx_q, stage_idx_d;
    logic            rd_bank_q, rd_bank_d;
    logic [7:0]      frame_cnt_q, frame_cnt_d;
    logic            stage_start_q, stage_start_d;
    logic            result_valid_q, result_valid_d;
    logic            result_bank_q, result_bank_d;
    logic            busy_q, busy_d;

`ifdef FFT_STAGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_err_q, timeout_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        stage_idx_d = stage_idx_q;
        rd_bank_d   = rd_bank_q;
        frame_cnt_d = frame_cnt_q;
`ifdef FFT_STAGE_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.frame_valid) begin
                    stage_idx_d = '0;
                    rd_bank_d   = 1'b0;
`ifdef FFT_STAGE_TIMEOUT_EN
                    timeout_err_d = 1'b0;
`endif
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
`ifdef FFT_STAGE_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.stage_done) begin
                    state_d = ADVANCE;
                end
`ifdef FFT_STAGE_TIMEOUT_EN
                // The TIMEOUT-th WAIT cycle without a done pulse aborts the frame.
                else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
`endif
            end
            ADVANCE: begin
                rd_bank_d = ~rd_bank_q;
                if (stage_idx_q == LAST_STAGE) begin
                    state_d = RESULT;
                end else begin
                    stage_idx_d = stage_idx_q + SIZE'(1);
                    state_d     = ISSUE;
                end
            end
            RESULT: begin
                if (bus.result_ready) begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered outputs are decoded from the next state so they align with it.
        stage_start_d  = (state_d == ISSUE);
        result_valid_d = (state_d == RESULT);
        busy_d         = (state_d != IDLE);
        result_bank_d  = (state_d == RESULT) ? rd_bank_d : result_bank_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            stage_idx_q    <= '0;
            rd_bank_q      <= 1'b0;
            frame_cnt_q    <= 8'd0;
            stage_start_q  <= 1'b0;
            result_valid_q <= 1'b0;
            result_bank_q  <= 1'b0;
            busy_q         <= 1'b0;
`ifdef FFT_STAGE_TIMEOUT_EN
            wait_cnt_q     <= '0;
            timeout_err_q  <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            stage_idx_q    <= stage_idx_d;
            rd_bank_q      <= rd_bank_d;
            frame_cnt_q    <= frame_cnt_d;
            stage_start_q  <= stage_start_d;
            result_valid_q <= result_valid_d;
            result_bank_q  <= result_bank_d;
            busy_q         <= busy_d;
`ifdef FFT_STAGE_TIMEOUT_EN
            wait_cnt_q     <= wait_cnt_d;
            timeout_err_q  <= timeout_err_d;
`endif
        end
    end

    assign bus.frame_ready  = (state_q == IDLE);
    assign bus.stage_start  = stage_start_q;
    assign bus.stage_idx    = stage_idx_q;
    assign bus.tw_shift     = LAST_STAGE - stage_idx_q;
    assign bus.result_valid = result_valid_q;
    assign bus.result_bank  = result_bank_q;

    assign rd_bank   = rd_bank_q;
    assign wr_bank   = ~rd_bank_q;
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;

`ifdef FFT_STAGE_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_fft_stage_scheduler.sv
// Directed bench for fft_stage_scheduler: nominal frame, latency, backpressure,
// spurious inputs, mid-frame reset and (with FFT_STAGE_TIMEOUT_EN) the watchdog.
module tb_fft_stage_scheduler;

    localparam int SIZE = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rd_bank, wr_bank, busy, timeout_err;
    logic [7:0] frame_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    fft_stage_scheduler_if #(.SIZE(SIZE)) bus ();

    fft_stage_scheduler #(.N(16), .SIZE(SIZE), .TIMEOUT(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .rd_bank     (rd_bank),
        .wr_bank     (wr_bank),
        .busy        (busy),
        .frame_cnt   (frame_cnt),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Emulated stage controller: wait for stage_start, capture its context,
    // then pulse stage_done d cycles later (d == 0 means never answer).
    task automatic run_stage(input int d, output logic found,
                             output logic [SIZE-1:0] idx, output logic [SIZE-1:0] tw,
                             output logic rb, output logic wb);
        found = 1'b0;
        idx = '0; tw = '0; rb = 1'b0; wb = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (bus.stage_start === 1'b1) found = 1'b1;
            else tick();
        end
        if (found) begin
            idx = bus.stage_idx;
            tw  = bus.tw_shift;
            rb  = rd_bank;
            wb  = wr_bank;
            if (d > 0) begin
                for (int i = 0; i < d; i++) tick();
                bus.stage_done = 1'b1;
                tick();
                bus.stage_done = 1'b0;
            end
        end
    endtask

    task automatic accept_frame();
        bus.frame_valid = 1'b1;
        tick();
        bus.frame_valid = 1'b0;
    endtask

    task automatic wait_result(output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (bus.result_valid === 1'b1) seen = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        total_cnt++;
        if ({bus.frame_ready, bus.stage_start, bus.result_valid, bus.result_bank, busy, rd_bank, wr_bank, timeout_err} !== 8'b1000_0010)
            $display("[TB] FAIL reset_flags: got %b expected 10000010",
                     {bus.frame_ready, bus.stage_start, bus.result_valid, bus.result_bank, busy, rd_bank, wr_bank, timeout_err});
        else pass_cnt++;
        total_cnt++;
        if (bus.stage_idx !== 4'd0 || bus.tw_shift !== 4'd3 || frame_cnt !== 8'd0)
            $display("[TB] FAIL reset_values: idx=%0d tw=%0d cnt=%0d expected 0/3/0",
                     bus.stage_idx, bus.tw_shift, frame_cnt);
        else pass_cnt++;
    endtask

    task automatic test_nominal();
        logic found, seen, rb, wb;
        logic [SIZE-1:0] idx, tw;
        accept_frame();
        for (int s = 0; s < SIZE; s++) begin
            run_stage(5, found, idx, tw, rb, wb);
            total_cnt++;
            if (found !== 1'b1 || idx !== 4'(s) || tw !== 4'(3 - s) || rb !== 1'(s % 2) || wb !== 1'(~s % 2 != 0))
                $display("[TB] FAIL nominal_stage%0d: found=%0d idx=%0d tw=%0d rd=%0d wr=%0d expected 1/%0d/%0d/%0d/%0d",
                         s, found, idx, tw, rb, wb, s, 3 - s, s % 2, 1 - s % 2);
            else pass_cnt++;
        end
        tick();
        total_cnt++;
        if (bus.result_valid !== 1'b1 || bus.result_bank !== 1'b0 || busy !== 1'b1 || frame_cnt !== 8'd0 || bus.frame_ready !== 1'b0)
            $display("[TB] FAIL nominal_result: valid=%0d bank=%0d busy=%0d cnt=%0d ready=%0d expected 1/0/1/0/0",
                     bus.result_valid, bus.result_bank, busy, frame_cnt, bus.frame_ready);
        else pass_cnt++;
        bus.result_ready = 1'b1;
        tick();
        bus.result_ready = 1'b0;
        total_cnt++;
        if (bus.result_valid !== 1'b0 || bus.frame_ready !== 1'b1 || busy !== 1'b0 || frame_cnt !== 8'd1)
            $display("[TB] FAIL nominal_done: valid=%0d ready=%0d busy=%0d cnt=%0d expected 0/1/0/1",
                     bus.result_valid, bus.frame_ready, busy, frame_cnt);
        else pass_cnt++;
        wait_result(seen);
        total_cnt++;
        if (seen !== 1'b0)
            $display("[TB] FAIL nominal_no_extra_result: got %0d expected 0", seen);
        else pass_cnt++;
    endtask

    task automatic test_min_latency();
        logic found, seen, rb, wb;
        logic [SIZE-1:0] idx, tw;
        int t0;
        accept_frame();
        t0 = cyc;
        for (int s = 0; s < SIZE; s++) run_stage(1, found, idx, tw, rb, wb);
        wait_result(seen);
        total_cnt++;
        if (seen !== 1'b1 || (cyc - t0 + 1) !== 13)
            $display("[TB] FAIL min_latency: seen=%0d latency=%0d expected 1/13", seen, cyc - t0 + 1);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        for (int i = 0; i < 10; i++) begin
            bus.frame_valid = (i == 3 || i == 4);
            if (bus.result_valid !== 1'b1 || bus.frame_ready !== 1'b0) bad++;
            tick();
        end
        bus.frame_valid = 1'b0;
        total_cnt++;
        if (bad !== 0 || bus.result_valid !== 1'b1 || busy !== 1'b1 || bus.stage_start !== 1'b0)
            $display("[TB] FAIL backpressure_hold: bad=%0d valid=%0d busy=%0d start=%0d expected 0/1/1/0",
                     bad, bus.result_valid, busy, bus.stage_start);
        else pass_cnt++;
        bus.result_ready = 1'b1;
        bus.frame_valid  = 1'b1;
        tick();
        bus.result_ready = 1'b0;
        total_cnt++;
        if (bus.frame_ready !== 1'b1 || busy !== 1'b0 || bus.result_valid !== 1'b0 || frame_cnt !== 8'd2)
            $display("[TB] FAIL backpressure_release: ready=%0d busy=%0d valid=%0d cnt=%0d expected 1/0/0/2",
                     bus.frame_ready, busy, bus.result_valid, frame_cnt);
        else pass_cnt++;
        tick();
        bus.frame_valid = 1'b0;
        total_cnt++;
        if (busy !== 1'b1 || bus.stage_start !== 1'b1 || bus.stage_idx !== 4'd0)
            $display("[TB] FAIL back_to_back_accept: busy=%0d start=%0d idx=%0d expected 1/1/0",
                     busy, bus.stage_start, bus.stage_idx);
        else pass_cnt++;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_spurious();
        logic found, seen, rb, wb;
        logic [SIZE-1:0] idx, tw;
        bus.stage_done = 1'b1;
        tick();
        bus.stage_done = 1'b0;
        total_cnt++;
        if (busy !== 1'b0 || bus.frame_ready !== 1'b1 || bus.stage_start !== 1'b0)
            $display("[TB] FAIL spurious_idle_done: busy=%0d ready=%0d start=%0d expected 0/1/0",
                     busy, bus.frame_ready, bus.stage_start);
        else pass_cnt++;
        accept_frame();
        bus.stage_done = 1'b1;
        tick();
        bus.stage_done = 1'b0;
        bus.frame_valid = 1'b1;
        tick();
        tick();
        tick();
        bus.frame_valid = 1'b0;
        total_cnt++;
        if (rd_bank !== 1'b0 || bus.stage_idx !== 4'd0 || bus.stage_start !== 1'b0 || busy !== 1'b1 || bus.frame_ready !== 1'b0)
            $display("[TB] FAIL spurious_issue_wait: rd=%0d idx=%0d start=%0d busy=%0d ready=%0d expected 0/0/0/1/0",
                     rd_bank, bus.stage_idx, bus.stage_start, busy, bus.frame_ready);
        else pass_cnt++;
        bus.stage_done = 1'b1;
        tick();
        bus.stage_done = 1'b0;
        for (int s = 1; s < SIZE; s++) run_stage(2, found, idx, tw, rb, wb);
        wait_result(seen);
        total_cnt++;
        if (seen !== 1'b1 || bus.result_bank !== 1'b0 || idx !== 4'd3)
            $display("[TB] FAIL spurious_complete: seen=%0d bank=%0d last_idx=%0d expected 1/0/3",
                     seen, bus.result_bank, idx);
        else pass_cnt++;
        bus.result_ready = 1'b1;
        tick();
        bus.result_ready = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        logic found, seen, rb, wb;
        logic [SIZE-1:0] idx, tw;
        int starts = 0;
        total_cnt++;
        if (frame_cnt !== 8'd1)
            $display("[TB] FAIL pre_reset_cnt: got %0d expected 1", frame_cnt);
        else pass_cnt++;
        accept_frame();
        run_stage(1, found, idx, tw, rb, wb);
        run_stage(3, found, idx, tw, rb, wb);
        run_stage(0, found, idx, tw, rb, wb);
        tick();
        tick();
        rst_n = 1'b0;
        bus.stage_done = 1'b1;
        tick();
        rst_n = 1'b1;
        bus.stage_done = 1'b0;
        total_cnt++;
        if (busy !== 1'b0 || bus.stage_idx !== 4'd0 || rd_bank !== 1'b0 || frame_cnt !== 8'd0 || wr_bank !== 1'b1 || bus.tw_shift !== 4'd3)
            $display("[TB] FAIL reset_mid_frame: busy=%0d idx=%0d rd=%0d cnt=%0d wr=%0d tw=%0d expected 0/0/0/0/1/3",
                     busy, bus.stage_idx, rd_bank, frame_cnt, wr_bank, bus.tw_shift);
        else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            if (bus.stage_start !== 1'b0 || bus.result_valid !== 1'b0) starts++;
            tick();
        end
        total_cnt++;
        if (starts !== 0 || bus.frame_ready !== 1'b1)
            $display("[TB] FAIL reset_quiet: activity=%0d ready=%0d expected 0/1", starts, bus.frame_ready);
        else pass_cnt++;
    endtask

`ifdef FFT_STAGE_TIMEOUT_EN
    task automatic test_timeout();
        logic found, seen, rb, wb;
        logic [SIZE-1:0] idx, tw;
        accept_frame();
        run_stage(1, found, idx, tw, rb, wb);
        run_stage(0, found, idx, tw, rb, wb);
        for (int i = 0; i < 64; i++) tick();
        total_cnt++;
        if (found !== 1'b1 || idx !== 4'd1 || timeout_err !== 1'b0 || busy !== 1'b1)
            $display("[TB] FAIL timeout_before: found=%0d idx=%0d err=%0d busy=%0d expected 1/1/0/1",
                     found, idx, timeout_err, busy);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (timeout_err !== 1'b1 || busy !== 1'b0 || bus.frame_ready !== 1'b1 || frame_cnt !== 8'd0)
            $display("[TB] FAIL timeout_fire: err=%0d busy=%0d ready=%0d cnt=%0d expected 1/0/1/0",
                     timeout_err, busy, bus.frame_ready, frame_cnt);
        else pass_cnt++;
        wait_result(seen);
        total_cnt++;
        if (seen !== 1'b0 || timeout_err !== 1'b1)
            $display("[TB] FAIL timeout_sticky: result=%0d err=%0d expected 0/1", seen, timeout_err);
        else pass_cnt++;
        accept_frame();
        total_cnt++;
        if (timeout_err !== 1'b0 || busy !== 1'b1)
            $display("[TB] FAIL timeout_clear: err=%0d busy=%0d expected 0/1", timeout_err, busy);
        else pass_cnt++;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask
`else
    task automatic test_timeout();
        logic found, rb, wb;
        logic [SIZE-1:0] idx, tw;
        accept_frame();
        run_stage(0, found, idx, tw, rb, wb);
        for (int i = 0; i < 80; i++) tick();
        total_cnt++;
        if (timeout_err !== 1'b0 || busy !== 1'b1 || bus.result_valid !== 1'b0)
            $display("[TB] FAIL no_watchdog_wait: err=%0d busy=%0d valid=%0d expected 0/1/0",
                     timeout_err, busy, bus.result_valid);
        else pass_cnt++;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        bus.frame_valid  = 1'b0;
        bus.stage_done   = 1'b0;
        bus.result_ready = 1'b0;
        rst_n            = 1'b0;
        test_reset();
        test_nominal();
        test_min_latency();
        test_back_to_back();
        test_spurious();
        test_reset_mid_frame();
        test_timeout();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
